// File: rtl/energy_det_pkg.sv
// energy_det_pkg: FSM state encoding and accumulator width derivation shared by the detector.
package energy_det_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, REPORT} state_t;
  function automatic int acc_width(input int sample_w, input int log2_max_win);
    return 2 * sample_w + log2_max_win;
  endfunction
endpackage

// File: rtl/energy_sq_acc.sv
// energy_sq_acc: squares an I/Q pair at full precision and accumulates I^2+Q^2 with clear/enable.
module energy_sq_acc
  import energy_det_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int LOG2_MAX_WIN = 10,
  localparam int ACC_W = acc_width(SAMPLE_W, LOG2_MAX_WIN)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] din_i,
  input  logic signed [SAMPLE_W-1:0] din_q,
  output logic [ACC_W-1:0]           acc
);
  logic signed [2*SAMPLE_W-1:0] ext_i, ext_q, sq_i, sq_q;
  logic [2*SAMPLE_W:0] sum;
  // operands are sign-extended first so (-2^(SAMPLE_W-1))^2 is exact
  assign ext_i = (2*SAMPLE_W)'(din_i);
  assign ext_q = (2*SAMPLE_W)'(din_q);
  assign sq_i = ext_i * ext_i;
  assign sq_q = ext_q * ext_q;
  assign sum = {1'b0, sq_i} + {1'b0, sq_q};
  always_ff @(posedge clock) begin
    if (reset || clear) acc <= '0;
    else if (en) acc <= acc + ACC_W'(sum);
  end
endmodule

// File: rtl/energy_window_detector.sv
// energy_window_detector: pops windowed I/Q samples from a FIFO, sums their energy and
// raises detect after a run of consecutive above-threshold windows.
module energy_window_detector
  import energy_det_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int LOG2_MAX_WIN = 10,
  parameter int HIT_W = 4,
  localparam int ACC_W = acc_width(SAMPLE_W, LOG2_MAX_WIN)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       empty_fin,
  output logic                       pop_fin,
  input  logic signed [SAMPLE_W-1:0] din_i,
  input  logic signed [SAMPLE_W-1:0] din_q,
  input  logic [LOG2_MAX_WIN:0]      win_len,
  input  logic [ACC_W-1:0]           threshold,
  input  logic [HIT_W-1:0]           hits_req,
  output logic [ACC_W-1:0]           energy,
  output logic                       energy_valid,
  output logic                       end_sig,
  output logic                       detect
);
  localparam logic [LOG2_MAX_WIN:0] MAX_LEN = {1'b1, {LOG2_MAX_WIN{1'b0}}};
  localparam logic [LOG2_MAX_WIN:0] ONE_LEN = {{LOG2_MAX_WIN{1'b0}}, 1'b1};
  state_t state;
  logic [LOG2_MAX_WIN:0] win_len_q, pop_cnt, len_c;
  logic [HIT_W-1:0] hit_cnt, hit_next, hits_min;
  logic [ACC_W-1:0] acc;
  logic dv, rpt, start, clear, above;
  assign len_c = (win_len == '0) ? ONE_LEN : (win_len > MAX_LEN) ? MAX_LEN : win_len;
  assign start = enable && !empty_fin;
  assign clear = start && (state == IDLE || state == REPORT);
  assign pop_fin = !reset && state == ACCUM && !empty_fin && pop_cnt < win_len_q;
  assign above = acc >= threshold;
  assign hit_next = above ? (&hit_cnt ? hit_cnt : hit_cnt + 1'b1) : '0;
  assign hits_min = (hits_req == '0) ? {{(HIT_W-1){1'b0}}, 1'b1} : hits_req;
  assign energy_valid = rpt && !reset;
  assign end_sig = rpt && !reset;
  energy_sq_acc #(.SAMPLE_W(SAMPLE_W), .LOG2_MAX_WIN(LOG2_MAX_WIN)) u_acc (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .en(dv),
    .din_i(din_i),
    .din_q(din_q),
    .acc(acc)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      win_len_q <= '0;
      pop_cnt <= '0;
      dv <= 1'b0;
      rpt <= 1'b0;
      hit_cnt <= '0;
      energy <= '0;
      detect <= 1'b0;
    end else begin
      dv <= pop_fin;
      rpt <= state == COMPARE;
      if (pop_fin) pop_cnt <= pop_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= ACCUM;
          win_len_q <= len_c;
          pop_cnt <= '0;
        end
        ACCUM: if (dv && pop_cnt == win_len_q) state <= COMPARE;
        COMPARE: begin
          energy <= acc;
          hit_cnt <= hit_next;
          detect <= hit_next >= hits_min;
          state <= REPORT;
        end
        REPORT: begin
          state <= start ? ACCUM : IDLE;
          if (start) begin
            win_len_q <= len_c;
            pop_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/energy_window_detector.md
ENERGY_WINDOW_DETECTOR -- requirements
Module: energy_window_detector

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, signed I/Q sample width.
REQ-002 SHALL have parameter LOG2_MAX_WIN, default 10, maximum window length 2^LOG2_MAX_WIN samples.
REQ-003 SHALL have parameter HIT_W, default 4, consecutive-hit counter width.
REQ-004 SHALL derive ACC_W = 2*SAMPLE_W + LOG2_MAX_WIN; no overflow is possible at any legal window length.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 enable  in  1  start/continue windows while high.
REQ-008 empty_fin  in  1  input FIFO empty.
REQ-009 pop_fin  out  1  input FIFO pop; din_i/din_q valid the cycle after a pop.
REQ-010 din_i, din_q  in  SAMPLE_W each  signed sample.
REQ-011 win_len  in  LOG2_MAX_WIN+1  window length, latched at window start.
REQ-012 threshold  in  ACC_W  unsigned energy threshold.
REQ-013 hits_req  in  HIT_W  consecutive above-threshold windows needed for detect.
REQ-014 energy  out  ACC_W  sum of I^2+Q^2 over last completed window.
REQ-015 energy_valid  out  1  one-cycle pulse, energy updated.
REQ-016 end_sig  out  1  one-cycle pulse coincident with energy_valid.
REQ-017 detect  out  1  registered detection level.

Function
REQ-018 FSM states SHALL be IDLE, ACCUM, COMPARE, REPORT.
REQ-019 IDLE: enable=1 and empty_fin=0 -> ACCUM; latch win_len (0 -> 1, >2^LOG2_MAX_WIN -> clamp), clear accumulator and pop counter.
REQ-020 ACCUM: pop_fin = !empty_fin && pop_cnt < win_len_q, combinational; pop_fin never asserted when empty_fin=1.
REQ-021 Data-valid flag dv SHALL be pop_fin delayed one cycle; each dv cycle adds din_i^2 + din_q^2 to accumulator.
REQ-022 Empty FIFO mid-window SHALL stall without losing, duplicating or padding samples.
REQ-023 ACCUM -> COMPARE on cycle where dv=1 and pop_cnt == win_len_q (last sample accumulated at that edge).
REQ-024 COMPARE: energy <= acc; above = (acc >= threshold); hit_cnt <= above ? sat_inc(hit_cnt) : 0; detect <= (next hit_cnt >= max(hits_req,1)).
REQ-025 REPORT: energy_valid=1, end_sig=1 for exactly one cycle; then enable=1 and empty_fin=0 -> ACCUM (re-latch win_len, clear acc), else IDLE.
REQ-026 Latency: energy_valid SHALL assert exactly 2 cycles after the edge accumulating the last sample.
REQ-027 enable deassert mid-window SHALL let the current window complete and report, then go IDLE.
REQ-028 hit_cnt SHALL saturate at 2^HIT_W-1; detect holds between reports, clears on first below-threshold window.
REQ-029 Squares computed at full 2*SAMPLE_W precision; -2^(SAMPLE_W-1) handled exactly.
REQ-030 Unreachable state encodings SHALL return to IDLE.

Reset
REQ-031 reset=1 SHALL on next edge force IDLE, acc=0, pop_cnt=0, dv=0, hit_cnt=0, energy=0, detect=0; energy_valid, end_sig, pop_fin low while reset high.
REQ-032 Reset mid-window SHALL discard partial energy; next window uses a freshly latched win_len.

Structure
REQ-033 Package energy_det_pkg SHALL hold the state encoding and ACC_W derivation function.
REQ-034 Sub-module energy_sq_acc (squarer + accumulator with clear/enable) SHALL hold the datapath; FSM, counters, compare in top.

Verification (SAMPLE_W=16, LOG2_MAX_WIN=4, HIT_W=4)
REQ-035 win_len=4, samples (3,4), threshold=99, hits_req=1 -> energy=100, energy_valid 2 cycles after 4th accumulation, detect=1.
REQ-036 Same, empty_fin high 5 cycles after 2nd pop -> pop_fin low during empty, energy=100, exactly 4 pops.
REQ-037 hits_req=3, windows energy 100,100,100,50 with threshold=99 -> detect rises on 3rd energy_valid, falls on 4th.
REQ-038 win_len=16, all samples (-32768,-32768) -> energy=34359738368 (2^35), no wrap.
REQ-039 reset after 2nd sample of window -> next cycle all outputs 0, state IDLE; following window with win_len=2, samples (1,1) -> energy=4.
REQ-040 win_len=0, sample (2,0), threshold=5 -> window of 1 sample, energy=4, detect=0; enable dropped mid-window -> window completes, then IDLE.
